// File: rtl/axilite_rsa_regs.sv
// rtl/axilite_rsa_regs.sv - AXI4-Lite register bank for the RSA core
//
// Purpose: terminates AXI4-Lite transactions and holds the RSA core's
// CTRL, STATUS and OPERAND registers.
//   word 0 CTRL    : bit0 START (write-1 pulse), bit1 DONE_CLR (write-1), reads 0
//   word 1 STATUS  : bit0 busy (live), bit1 DONE (sticky), bit2 OVERRUN (sticky)
//   word 2..N-1    : OPERAND read/write, exported on operand_bus
// Out-of-range word indices answer SLVERR; writes to them are dropped.
//
// Optional feature: define AXIL_RSA_REGS_WSTRB_EN to honour WSTRB per byte on
// OPERAND writes and to gate CTRL actions on WSTRB[0]. Without it every
// accepted write updates the full word.
//
// Ports:
//   ACLK, ARESET         clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*      AXI4-Lite write address, data and response channels
//   S_AXI_AR*/R*         AXI4-Lite read address and data channels
//   core_start           one-cycle start pulse toward the core
//   core_busy, core_done core status (level, one-cycle pulse)
//   operand_bus          regs 2..NUM_REGS-1 concatenated, reg 2 in the LSBs
module axilite_rsa_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS           = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic                          core_start,
  input  logic                          core_busy,
  input  logic                          core_done,
  output logic [32*(NUM_REGS-2)-1:0]    operand_bus
);

  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [IDX_W:0] NUM_REGS_V = NUM_REGS[IDX_W:0];
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [31:0]      operand_q [NUM_REGS-2];   // element k holds register k+2
  logic             done_q;
  logic             overrun_q;
  logic [IDX_W-1:0] rd_idx_q;

  logic [IDX_W-1:0] wr_idx;
  logic             wr_in_range;
  logic             aw_accept;
  logic             ar_accept;
  logic [31:0]      wr_mask;
  logic             ctrl_en;
  logic             start_req;
  logic             start_ok;
  logic             done_clr;
  logic [31:0]      rd_data_c;
  logic             rd_err_c;
  logic             unused_inputs;

  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                           S_AXI_ARADDR[1:0], S_AXI_WSTRB};

  assign wr_idx      = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_in_range = ({1'b0, wr_idx} < NUM_REGS_V);

  // Address and data are taken together; the ready check keeps one write
  // from being accepted twice while the master is still presenting it.
  assign aw_accept = S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID &&
                     !S_AXI_AWREADY && !S_AXI_WREADY;
  assign ar_accept = S_AXI_ARVALID && !S_AXI_RVALID && !S_AXI_ARREADY;

`ifdef AXIL_RSA_REGS_WSTRB_EN
  assign wr_mask = {{8{S_AXI_WSTRB[3]}}, {8{S_AXI_WSTRB[2]}},
                    {8{S_AXI_WSTRB[1]}}, {8{S_AXI_WSTRB[0]}}};
  assign ctrl_en = S_AXI_WSTRB[0];
`else
  assign wr_mask = 32'hFFFF_FFFF;
  assign ctrl_en = 1'b1;
`endif

  assign start_req = aw_accept && (wr_idx == '0) && ctrl_en && S_AXI_WDATA[0];
  assign done_clr  = aw_accept && (wr_idx == '0) && ctrl_en && S_AXI_WDATA[1];
  // A start while the core is busy, or while the previous pulse is still out,
  // is refused and flagged instead of being queued.
  assign start_ok  = start_req && !core_busy && !core_start;

  // Write channel, CTRL side effects and register storage
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      core_start    <= 1'b0;
      done_q        <= 1'b0;
      overrun_q     <= 1'b0;
      for (int k = 0; k < NUM_REGS - 2; k++) begin
        operand_q[k] <= '0;
      end
    end else begin
      S_AXI_AWREADY <= aw_accept;
      S_AXI_WREADY  <= aw_accept;
      core_start    <= start_ok;

      if (aw_accept) begin
        S_AXI_BRESP <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end

      if (S_AXI_AWREADY) begin
        S_AXI_BVALID <= 1'b1;
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end

      // Set terms are ORed after the clear so a coincident set wins.
      done_q    <= core_done | (done_q & !done_clr);
      overrun_q <= (start_req & !start_ok) | (overrun_q & !done_clr);

      if (aw_accept) begin
        for (int k = 0; k < NUM_REGS - 2; k++) begin
          if (wr_idx == IDX_W'(k + 2)) begin
            operand_q[k] <= (operand_q[k] & ~wr_mask) | (S_AXI_WDATA & wr_mask);
          end
        end
      end
    end
  end

  // Read data selection from the latched word index
  always_comb begin
    rd_data_c = '0;
    rd_err_c  = ({1'b0, rd_idx_q} >= NUM_REGS_V);
    if (rd_idx_q == IDX_W'(1)) begin
      rd_data_c = {29'b0, overrun_q, done_q, core_busy};
    end
    for (int k = 0; k < NUM_REGS - 2; k++) begin
      if (rd_idx_q == IDX_W'(k + 2)) begin
        rd_data_c = operand_q[k];
      end
    end
  end

  // Read channel
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
      rd_idx_q      <= '0;
    end else begin
      S_AXI_ARREADY <= ar_accept;
      if (ar_accept) begin
        rd_idx_q <= S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
      end

      if (S_AXI_ARREADY) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_data_c;
        S_AXI_RRESP  <= rd_err_c ? RESP_SLVERR : RESP_OKAY;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS - 2; g++) begin : g_operand_bus
    assign operand_bus[32*g +: 32] = operand_q[g];
  end

endmodule
